// File: rtl/adf_multi_reg_programmer.sv
// ADF4159 multi-register programmer: shadow bank plus a 3-wire serialiser that sends R[N-1]..R0.
// Optional ADF_DIRTY_ONLY_EN: only dirty words are sent (R0 always included when anything is sent).
module adf_multi_reg_programmer #(
  parameter int NUM_REGS   = 8,
  parameter int WORD_W     = 32,
  parameter int ADDR_BITS  = 3,
  parameter int CLK_DIV    = 4,
  parameter int FORCE_ADDR = 1
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] wr_addr,
  input  logic [WORD_W-1:0]           wr_data,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr,
  output logic [WORD_W-1:0]           rd_data,
  input  logic                        go,
  output logic                        busy,
  output logic                        done,
  output logic                        spi_sclk,
  output logic                        spi_sdata,
  output logic                        spi_le
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(WORD_W + 1);
  localparam logic [AW:0]    NREGS = (AW+1)'(NUM_REGS);
  localparam logic [AW-1:0]  TOP   = AW'(NUM_REGS - 1);
  localparam logic [DW-1:0]  DLAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0]  BLAST = BW'(WORD_W - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD     = 3'd1;
  localparam logic [2:0] SHIFT    = 3'd2;
  localparam logic [2:0] LE_SETUP = 3'd3;
  localparam logic [2:0] LE_HIGH  = 3'd4;
  localparam logic [2:0] GAP      = 3'd5;

  logic [WORD_W-1:0] shadow [NUM_REGS];
  logic [2:0]        state;
  logic [AW-1:0]     idx;
  logic [WORD_W-1:0] shifter;
  logic [DW-1:0]     cnt;
  logic [BW-1:0]     bit_cnt;
  logic              pending;
  logic              wr_ok, rd_ok, div_end;
  logic [WORD_W-1:0] load_word;
  logic              any_dirty;
  logic [AW-1:0]     first_idx, next_idx;

  assign wr_ok   = {1'b0, wr_addr} < NREGS;
  assign rd_ok   = {1'b0, rd_addr} < NREGS;
  assign div_end = (cnt == DLAST);

  always_comb begin
    load_word = shadow[idx];
    if (FORCE_ADDR != 0) load_word[ADDR_BITS-1:0] = ADDR_BITS'(idx);
  end

`ifdef ADF_DIRTY_ONLY_EN
  logic [NUM_REGS-1:0] dirty;

  // first_idx: highest dirty word; next_idx: highest dirty word below idx, else R0
  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (dirty[i]) begin
        first_idx = AW'(i);
        if (AW'(i) < idx) next_idx = AW'(i);
      end
    end
  end
  assign any_dirty = |dirty;

  // A write landing on the LOAD cycle keeps the word dirty, since the old value was captured
  always_ff @(posedge ACLK) begin
    if (ARESET) dirty <= '1;
    else begin
      if (state == LOAD) dirty[idx] <= 1'b0;
      if (wr_en && wr_ok) dirty[wr_addr] <= 1'b1;
    end
  end
`else
  assign any_dirty = 1'b1;
  assign first_idx = TOP;
  assign next_idx  = idx - 1'b1;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en && wr_ok) shadow[wr_addr] <= wr_data;
      rd_data <= rd_ok ? shadow[rd_addr] : '0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= IDLE;
      idx       <= '0;
      shifter   <= '0;
      cnt       <= '0;
      bit_cnt   <= '0;
      pending   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      spi_sclk  <= 1'b0;
      spi_sdata <= 1'b0;
      spi_le    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go && busy) pending <= 1'b1;
      case (state)
        IDLE: begin
          spi_sclk  <= 1'b0;
          spi_sdata <= 1'b0;
          spi_le    <= 1'b0;
          if (go || pending) begin
            pending <= 1'b0;
            if (any_dirty) begin
              idx   <= first_idx;
              busy  <= 1'b1;
              state <= LOAD;
            end else begin
              done <= 1'b1;
            end
          end
        end
        LOAD: begin
          shifter   <= load_word;
          spi_sdata <= load_word[WORD_W-1];
          spi_sclk  <= 1'b0;
          cnt       <= '0;
          bit_cnt   <= '0;
          state     <= SHIFT;
        end
        SHIFT: begin
          if (div_end) begin
            cnt <= '0;
            if (!spi_sclk) spi_sclk <= 1'b1;
            else begin
              // falling edge: present the next bit, or finish the word
              spi_sclk <= 1'b0;
              if (bit_cnt == BLAST) begin
                spi_sdata <= 1'b0;
                state     <= LE_SETUP;
              end else begin
                bit_cnt   <= bit_cnt + 1'b1;
                shifter   <= {shifter[WORD_W-2:0], 1'b0};
                spi_sdata <= shifter[WORD_W-2];
              end
            end
          end else cnt <= cnt + 1'b1;
        end
        LE_SETUP: begin
          if (div_end) begin
            cnt    <= '0;
            spi_le <= 1'b1;
            state  <= LE_HIGH;
          end else cnt <= cnt + 1'b1;
        end
        LE_HIGH: begin
          if (div_end) begin
            cnt    <= '0;
            spi_le <= 1'b0;
            state  <= GAP;
          end else cnt <= cnt + 1'b1;
        end
        GAP: begin
          if (div_end) begin
            cnt <= '0;
            if (idx == '0) begin
              done    <= 1'b1;
              pending <= 1'b0;
              // queued go (including one arriving this cycle) restarts without dropping busy
              if ((go || pending) && any_dirty) begin
                idx   <= first_idx;
                state <= LOAD;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              idx   <= next_idx;
              state <= LOAD;
            end
          end else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/adf_multi_reg_programmer.md
Name: adf_multi_reg_programmer

Overview:
Parametrised successor to the single-register ADF4159 AXI-lite register path. Holds a bank of NUM_REGS shadow words and, on a go strobe, serialises them to the PLL over the 3-wire SCLK/SDATA/LE interface in descending index order (R[N-1] first, R0 last), as the ADF4159 requires. Sits between the AXI4-Lite slave decode (simple write/read strobes) and the chip pins. Adds programmable SCLK rate, automatic address-field insertion and queued re-programming.

Parameters:
NUM_REGS, 8, number of shadow registers (2..16)
WORD_W, 32, bits per serial word, shifted MSB first
ADDR_BITS, 3, width of the control/address field in word bits [ADDR_BITS-1:0]
CLK_DIV, 4, ACLK cycles per SCLK half-period (>=1)
FORCE_ADDR, 1, 1: bits [ADDR_BITS-1:0] of every shifted word are replaced by the register index

Ports:
ACLK  in  1  system clock
ARESET  in  1  synchronous active-high reset
wr_en  in  1  shadow write strobe
wr_addr  in  clog2(NUM_REGS)  shadow write index
wr_data  in  WORD_W  shadow write data
rd_addr  in  clog2(NUM_REGS)  shadow read index
rd_data  out  WORD_W  shadow read data, 1-cycle latency
go  in  1  start programming sequence (single-cycle pulse)
busy  out  1  sequence in progress
done  out  1  one-cycle pulse at end of sequence
spi_sclk  out  1  serial clock to PLL
spi_sdata  out  1  serial data to PLL
spi_le  out  1  latch enable to PLL

Behaviour:
- Clock: ACLK only. Reset: ARESET synchronous active-high.
- Reset values: shadow words 0, rd_data 0, busy 0, done 0, spi_sclk 0, spi_sdata 0, spi_le 0, pending 0, FSM IDLE. ARESET mid-sequence aborts at that edge; no further LE pulse is issued.
- Shadow writes: accepted every cycle, including while busy. A word is captured into the shifter in LOAD, so a write to an index not yet loaded affects the current sequence; a write to an already-shifted index does not.
- Out-of-range wr_addr or rd_addr (>= NUM_REGS): write ignored, read returns 0.
- rd_data is registered from the shadow bank.
- FSM states: IDLE, LOAD, SHIFT, LE_SETUP, LE_HIGH, GAP.
  - IDLE: on go or pending set idx = NUM_REGS-1, clear pending, set busy, go to LOAD.
  - LOAD, 1 cycle: shifter = shadow[idx]; if FORCE_ADDR, low ADDR_BITS = idx; spi_sdata = shifter MSB; spi_sclk = 0.
  - SHIFT, per bit: D = CLK_DIV cycles with sclk 0, then D cycles with sclk 1. The PLL samples on the rising edge. sdata advances on the sclk falling transition. After WORD_W bits (2*WORD_W*D cycles), sclk returns to 0.
  - LE_SETUP: D cycles, sclk 0, le 0.
  - LE_HIGH: D cycles, le 1.
  - GAP: D cycles, le 0. Then if idx == 0: done pulses 1 cycle, busy drops on the same edge, go to IDLE. Otherwise idx decrements and the FSM goes to LOAD.
- Per-register time = 1 + 2*WORD_W*D + 3*D cycles. Full sequence = NUM_REGS times that.
- go while busy sets pending (depth 1, further go pulses are merged). When pending is set, the FSM goes to LOAD directly after the final GAP. done still pulses for the finished sequence, and busy stays 1.
- go on the same cycle as the final GAP exit counts as pending.
- spi_sdata holds 0 in IDLE.

Optional Feature:
- Macro: ADF_DIRTY_ONLY_EN.
- Defined:
  - Each shadow word has a dirty bit, set by wr_en to that index and cleared when the word is captured in LOAD.
  - The sequence visits only dirty indices, still in descending order; clean indices are skipped with 0 cycles.
  - Index 0 is always sent if any register is sent, because R0 write triggers the PLL update.
  - go with no dirty bits produces done 1 cycle later, busy stays 0, and no pins toggle.
  - Reset sets all dirty bits to 1.
- Not defined: every sequence sends all NUM_REGS words. There are no dirty bits.

Test Plan:
- Reset then go, NUM_REGS=8, WORD_W=32, D=4, shadows 0, FORCE_ADDR=1 -> 8 LE pulses; decoded words 0x7,0x6,...,0x0; busy high for exactly 8*(1+256+12)=2152 cycles; done one pulse.
- Write idx 2 = 0xDEADBEE8, read idx 2 -> rd_data 0xDEADBEE8 one cycle after rd_addr; shifted word for R2 = 0xDEADBEEA; sclk high/low periods each 4 ACLK.
- During R5 shift, write idx 6 = 0x11111111 and idx 1 = 0x22222222 -> R6 word unchanged in this sequence; R1 word 0x22222221.
- go during busy, twice -> exactly one extra sequence; done pulses twice in total; busy never drops between the two sequences.
- ARESET asserted mid-shift of R3 -> next edge: all pins 0, busy 0, no LE pulse; shadows read 0.
- ADF_DIRTY_ONLY_EN: after a full sequence, write idx 4 only, then go -> two words sent (R4, R0); second go with no writes -> done at +1 cycle, no pin activity.
